// File: rtl/audio_proc_pkg.sv
// Shared mode encodings, FSM state constants and saturation bounds for the audio loopback path.
package audio_proc_pkg;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_GAIN = 2'd1;
  localparam logic [1:0] MODE_REV  = 2'd2;
  localparam logic [1:0] MODE_MONO = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WAIT  = 2'd1;
  localparam state_t ST_PROC  = 2'd2;
  localparam state_t ST_WRITE = 2'd3;

  // Signed clamp limits for an sw-bit two's complement sample
  function automatic longint sat_max(input int unsigned sw);
    return (64'sd1 <<< (sw - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int unsigned sw);
    return -(64'sd1 <<< (sw - 1));
  endfunction

endpackage

// File: rtl/audio_ch_gain_sat.sv
// One channel of fixed-point gain: full-width signed multiply, arithmetic shift, clamp with sat flag.
module audio_ch_gain_sat
  import audio_proc_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned GAIN_WIDTH   = 16,
  parameter int unsigned GAIN_FRAC    = 12
) (
  input  logic [SAMPLE_WIDTH-1:0] x,
  input  logic [GAIN_WIDTH-1:0]   g,
  output logic [SAMPLE_WIDTH-1:0] y_c,
  output logic                    sat_c
);

  localparam int unsigned PW = SAMPLE_WIDTH + GAIN_WIDTH;
  localparam logic signed [PW-1:0] MAXV = PW'(sat_max(SAMPLE_WIDTH));
  localparam logic signed [PW-1:0] MINV = PW'(sat_min(SAMPLE_WIDTH));

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  always_comb begin
    prod    = PW'($signed(x)) * PW'($signed(g));
    shifted = prod >>> GAIN_FRAC;
    y_c     = shifted[SAMPLE_WIDTH-1:0];
    sat_c   = 1'b0;
    if (shifted > MAXV) begin
      y_c   = MAXV[SAMPLE_WIDTH-1:0];
      sat_c = 1'b1;
    end else if (shifted < MINV) begin
      y_c   = MINV[SAMPLE_WIDTH-1:0];
      sat_c = 1'b1;
    end
  end

endmodule

// File: rtl/audio_loopback_proc.sv
// ADC FIFO -> DAC FIFO frame mover with gain, routing modes, mute and sticky saturation flags.
// Optional output peak meter (peak, peak_clr) enabled by AUDIO_PEAK_METER_EN.
module audio_loopback_proc
  import audio_proc_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned GAIN_WIDTH   = 16,
  parameter int unsigned GAIN_FRAC    = 12,
  parameter int unsigned RD_LATENCY   = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             adc_empty,
  output logic                             adc_rd,
  input  logic [SAMPLE_WIDTH*CHANNELS-1:0] adc_rdata,
  input  logic                             dac_full,
  output logic                             dac_wr,
  output logic [SAMPLE_WIDTH*CHANNELS-1:0] dac_wdata,
  input  logic [1:0]                       mode,
  input  logic [GAIN_WIDTH*CHANNELS-1:0]   gain,
  input  logic                             mute,
  input  logic                             sat_clr,
  output logic [CHANNELS-1:0]              sat_flag,
`ifdef AUDIO_PEAK_METER_EN
  input  logic                             peak_clr,
  output logic [SAMPLE_WIDTH*CHANNELS-1:0] peak,
`endif
  output logic [31:0]                      frame_cnt
);

  localparam int unsigned SW   = SAMPLE_WIDTH;
  localparam int unsigned DW   = SAMPLE_WIDTH * CHANNELS;
  localparam int unsigned SUMW = SAMPLE_WIDTH + $clog2(CHANNELS) + 1;
  localparam logic [1:0] LAT_END = 2'(RD_LATENCY);
  localparam logic signed [SUMW-1:0] DIV      = SUMW'(CHANNELS);
  localparam logic signed [SUMW-1:0] MONO_MAX = SUMW'(sat_max(SAMPLE_WIDTH));
  localparam logic signed [SUMW-1:0] MONO_MIN = SUMW'(sat_min(SAMPLE_WIDTH));

  state_t          state, state_nxt;
  logic [1:0]      lat_cnt, lat_nxt;
  logic [DW-1:0]   cap_q, cap_nxt, wdata_nxt;
  logic            rd_nxt, wr_nxt;
  logic [CHANNELS-1:0] sat_set, sat_nxt;
  logic [31:0]     cnt_nxt;

  wire  [DW-1:0]       result_c;
  wire  [CHANNELS-1:0] ch_sat_c;
  wire  signed [SUMW-1:0] acc [CHANNELS+1];
  logic signed [SUMW-1:0] mono_q_c;
  logic [SW-1:0]          mono_y_c;
  logic                   mono_sat_c;

  assign acc[0] = '0;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    wire [SW-1:0] gain_y;
    wire          gain_sat;

    audio_ch_gain_sat #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .GAIN_WIDTH   (GAIN_WIDTH),
      .GAIN_FRAC    (GAIN_FRAC)
    ) u_gain (
      .x     (cap_q[i*SW +: SW]),
      .g     (gain[i*GAIN_WIDTH +: GAIN_WIDTH]),
      .y_c   (gain_y),
      .sat_c (gain_sat)
    );

    assign acc[i+1] = acc[i] + SUMW'($signed(cap_q[i*SW +: SW]));

    assign result_c[i*SW +: SW] = mute                ? '0 :
                                  (mode == MODE_PASS) ? cap_q[i*SW +: SW] :
                                  (mode == MODE_GAIN) ? gain_y :
                                  (mode == MODE_REV)  ? cap_q[(CHANNELS-1-i)*SW +: SW] :
                                                        mono_y_c;

    assign ch_sat_c[i] = !mute && (((mode == MODE_GAIN) && gain_sat) ||
                                   ((mode == MODE_MONO) && mono_sat_c));
  end

  // Mono average rounded toward -inf: signed division truncates toward zero, so step down on a negative remainder
  always_comb begin
    mono_q_c = acc[CHANNELS] / DIV;
    if (((acc[CHANNELS] % DIV) != '0) && acc[CHANNELS][SUMW-1])
      mono_q_c = mono_q_c - SUMW'(1);
    mono_y_c   = mono_q_c[SW-1:0];
    mono_sat_c = 1'b0;
    if (mono_q_c > MONO_MAX) begin
      mono_y_c   = MONO_MAX[SW-1:0];
      mono_sat_c = 1'b1;
    end else if (mono_q_c < MONO_MIN) begin
      mono_y_c   = MONO_MIN[SW-1:0];
      mono_sat_c = 1'b1;
    end
  end

  // Frame FSM; WRITE can chain straight into the next read so the period is 3+RD_LATENCY
  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    cap_nxt   = cap_q;
    wdata_nxt = dac_wdata;
    rd_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    sat_set   = '0;
    cnt_nxt   = frame_cnt;
    case (state)
      ST_IDLE: begin
        if (!adc_empty) begin
          rd_nxt    = 1'b1;
          lat_nxt   = '0;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt == LAT_END) begin
          cap_nxt   = adc_rdata;
          state_nxt = ST_PROC;
        end else begin
          lat_nxt = lat_cnt + 2'd1;
        end
      end
      ST_PROC: begin
        wdata_nxt = result_c;
        sat_set   = ch_sat_c;
        state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (!dac_full) begin
          wr_nxt  = 1'b1;
          cnt_nxt = frame_cnt + 32'd1;
          if (!adc_empty) begin
            rd_nxt    = 1'b1;
            lat_nxt   = '0;
            state_nxt = ST_WAIT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    sat_nxt = sat_clr ? '0 : (sat_flag | sat_set);
  end

`ifdef AUDIO_PEAK_METER_EN
  localparam logic [SW-1:0] PEAK_MAX = SW'(sat_max(SAMPLE_WIDTH));
  localparam logic [SW-1:0] PEAK_MIN = SW'(sat_min(SAMPLE_WIDTH));

  wire [DW-1:0] peak_nxt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_peak
    wire [SW-1:0] y   = dac_wdata[i*SW +: SW];
    wire [SW-1:0] cur = peak[i*SW +: SW];
    wire [SW-1:0] mag = !y[SW-1]       ? y :
                        (y == PEAK_MIN) ? PEAK_MAX : (~y + SW'(1));

    assign peak_nxt[i*SW +: SW] = peak_clr               ? '0 :
                                  (dac_wr && (mag > cur)) ? mag : cur;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      cap_q     <= '0;
      adc_rd    <= 1'b0;
      dac_wr    <= 1'b0;
      dac_wdata <= '0;
      sat_flag  <= '0;
      frame_cnt <= '0;
`ifdef AUDIO_PEAK_METER_EN
      peak      <= '0;
`endif
    end else begin
      state     <= state_nxt;
      lat_cnt   <= lat_nxt;
      cap_q     <= cap_nxt;
      adc_rd    <= rd_nxt;
      dac_wr    <= wr_nxt;
      dac_wdata <= wdata_nxt;
      sat_flag  <= sat_nxt;
      frame_cnt <= cnt_nxt;
`ifdef AUDIO_PEAK_METER_EN
      peak      <= peak_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_audio_loopback_proc.sv
// Directed bench for audio_loopback_proc (default parameters) with behavioural ADC/DAC FIFO models.
module tb_audio_loopback_proc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        adc_empty;
  logic        adc_rd;
  logic [31:0] adc_rdata;
  logic        dac_full;
  logic        dac_wr;
  logic [31:0] dac_wdata;
  logic [1:0]  mode;
  logic [31:0] gain;
  logic        mute;
  logic        sat_clr;
  logic [1:0]  sat_flag;
  logic [31:0] frame_cnt;
`ifdef AUDIO_PEAK_METER_EN
  logic        peak_clr;
  logic [31:0] peak;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  logic [31:0] adc_q[$];
  logic [31:0] dac_q[$];

  always #5 clk = ~clk;

  audio_loopback_proc dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .adc_empty (adc_empty),
    .adc_rd    (adc_rd),
    .adc_rdata (adc_rdata),
    .dac_full  (dac_full),
    .dac_wr    (dac_wr),
    .dac_wdata (dac_wdata),
    .mode      (mode),
    .gain      (gain),
    .mute      (mute),
    .sat_clr   (sat_clr),
    .sat_flag  (sat_flag),
`ifdef AUDIO_PEAK_METER_EN
    .peak_clr  (peak_clr),
    .peak      (peak),
`endif
    .frame_cnt (frame_cnt)
  );

  // FIFO models: read data valid one cycle after adc_rd; DAC captures on dac_wr
  always @(posedge clk) begin
    if (adc_rd) begin
      rd_cnt++;
      if (adc_q.size() > 0) begin
        adc_empty <= (adc_q.size() == 1);
        adc_rdata <= adc_q.pop_front();
      end
    end
    if (dac_wr) dac_q.push_back(dac_wdata);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_adc(input logic [31:0] w);
    adc_q.push_back(w);
    adc_empty = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int k = 0;
    while (dac_q.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(dac_q.size()), 64'(n));
  endtask

  task automatic one_frame(input logic [31:0] din, input logic [31:0] dout, input string tag);
    push_adc(din);
    wait_frames(1, {tag, "_cnt"});
    chk(tag, dac_q.pop_front(), 64'(dout));
  endtask

  initial begin
    int errs;
    int rd0;
    reset_n   = 1'b0;
    adc_empty = 1'b1;
    adc_rdata = '0;
    dac_full  = 1'b0;
    mode      = 2'd0;
    gain      = '0;
    mute      = 1'b0;
    sat_clr   = 1'b0;
`ifdef AUDIO_PEAK_METER_EN
    peak_clr  = 1'b0;
`endif

    // Reset with a non-empty ADC FIFO
    push_adc(32'h1234_5678);
    repeat (5) @(negedge clk);
    chk("rst_rd_cnt", 64'(rd_cnt), 0);
    chk("rst_adc_rd", 64'(adc_rd), 0);
    chk("rst_dac_wr", 64'(dac_wr), 0);
    chk("rst_wdata", 64'(dac_wdata), 0);
    chk("rst_sat", 64'(sat_flag), 0);
    chk("rst_cnt", 64'(frame_cnt), 0);
    adc_q.delete();
    adc_empty = 1'b1;
    reset_n   = 1'b1;
    @(negedge clk);

    // Pass-through, four frames back to back
    push_adc(32'h1234_8000);
    push_adc(32'h7FFF_0001);
    push_adc(32'hFFFF_8000);
    push_adc(32'h0000_0000);
    wait_frames(4, "pass_frames");
    chk("pass_w0", dac_q.pop_front(), 64'h1234_8000);
    chk("pass_w1", dac_q.pop_front(), 64'h7FFF_0001);
    chk("pass_w2", dac_q.pop_front(), 64'hFFFF_8000);
    chk("pass_w3", dac_q.pop_front(), 64'h0000_0000);
    chk("pass_cnt", 64'(frame_cnt), 4);
    chk("pass_sat", 64'(sat_flag), 0);

    // Gain: ch0 x2 saturates, ch1 x0.5
    mode = 2'd1;
    gain = 32'h0800_2000;
    one_frame(32'h4000_4000, 32'h2000_7FFF, "gain_sat");
    chk("gain_flag", 64'(sat_flag), 64'h1);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    chk("gain_clr", 64'(sat_flag), 0);
    one_frame(32'h4000_C000, 32'h2000_8000, "gain_neg_edge");
    chk("gain_neg_flag", 64'(sat_flag), 0);
    sat_clr = 1'b1;
    one_frame(32'h4000_4000, 32'h2000_7FFF, "gain_clr_hold");
    @(negedge clk);
    chk("clr_priority", 64'(sat_flag), 0);
    sat_clr = 1'b0;
    @(negedge clk);
    chk("clr_no_reset", 64'(sat_flag), 0);

    // Back-pressure: 20 cycles of dac_full while the frame is held
    mode = 2'd0;
    dac_full = 1'b1;
    push_adc(32'h1111_2222);
    repeat (6) @(negedge clk);
    push_adc(32'h3333_4444);
    rd0  = rd_cnt;
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dac_wr !== 1'b0) errs++;
      if (dac_wdata !== 32'h1111_2222) errs++;
    end
    chk("stall_stable", 64'(errs), 0);
    chk("stall_no_rd", 64'(rd_cnt - rd0), 0);
    chk("stall_no_wr", 64'(dac_q.size()), 0);
    dac_full = 1'b0;
    wait_frames(2, "stall_frames");
    chk("stall_w0", dac_q.pop_front(), 64'h1111_2222);
    chk("stall_w1", dac_q.pop_front(), 64'h3333_4444);
    chk("stall_cnt", 64'(frame_cnt), 9);

    // Reverse, mono (incl. floor rounding of negative sums), mute
    mode = 2'd2;
    one_frame(32'hAAAA_5555, 32'h5555_AAAA, "rev");
    mode = 2'd3;
    one_frame(32'h7FFF_7FFF, 32'h7FFF_7FFF, "mono_max");
    one_frame(32'h8000_0001, 32'hC000_C000, "mono_neg");
    one_frame(32'hFFFF_0000, 32'hFFFF_FFFF, "mono_floor");
    chk("mono_sat", 64'(sat_flag), 0);
    mode = 2'd1;
    mute = 1'b1;
    one_frame(32'h4000_4000, 32'h0000_0000, "mute");
    @(negedge clk);
    chk("mute_sat", 64'(sat_flag), 0);
    chk("mute_cnt", 64'(frame_cnt), 14);
    mute = 1'b0;

    // frame_cnt wrap
    @(negedge clk);
    force dut.frame_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    chk("cnt_preset", 64'(frame_cnt), 64'hFFFF_FFFF);
    mode = 2'd0;
    one_frame(32'h0102_0304, 32'h0102_0304, "wrap_frame");
    chk("cnt_wrap", 64'(frame_cnt), 0);

`ifdef AUDIO_PEAK_METER_EN
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    chk("peak_clr", 64'(peak), 0);
    one_frame(32'h0100_8000, 32'h0100_8000, "peak_frame");
    @(negedge clk);
    chk("peak_val", 64'(peak), 64'h0100_7FFF);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
